// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: operation codes and FSM state encoding.
package shreg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_SAR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ROR   = 3'b110;
  localparam logic [2:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // True for the codes that run through the multi-step RUN state.
  function automatic logic is_step_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_SAR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/shreg_step.sv
// Purely combinational single-step shifter: computes the next register value and the bit
// that leaves (or wraps) for one shift/rotate step.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] o_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             out_bit_o
);

  always_comb begin
    next_q_o  = o_i;
    out_bit_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        next_q_o  = {o_i[WIDTH-2:0], ser_in_l_i};
        out_bit_o = o_i[WIDTH-1];
      end
      MODE_SHR: begin
        next_q_o  = {ser_in_r_i, o_i[WIDTH-1:1]};
        out_bit_o = o_i[0];
      end
      MODE_SAR: begin
        next_q_o  = {o_i[WIDTH-1], o_i[WIDTH-1:1]};
        out_bit_o = o_i[0];
      end
      MODE_ROL: begin
        next_q_o  = {o_i[WIDTH-2:0], o_i[WIDTH-1]};
        out_bit_o = o_i[WIDTH-1];
      end
      MODE_ROR: begin
        next_q_o  = {o_i[0], o_i[WIDTH-1:1]};
        out_bit_o = o_i[0];
      end
      default: begin
        next_q_o  = o_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load plus multi-step shift/rotate, one step per clock,
// with a start/busy/done handshake and serial pins for cascading.
module shift_register_universal
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ser_out_q, ser_out_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_q;
  logic               step_bit;

  shreg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i    (mode_q),
    .o_i       (q_q),
    .ser_in_l_i(ser_in_l),
    .ser_in_r_i(ser_in_r),
    .next_q_o  (step_q),
    .out_bit_o (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == MODE_LOAD) begin
            q_d    = load_data;
            done_d = 1'b1;
          end else if (is_step_mode(mode) && (shamt != '0)) begin
            mode_d  = mode;
            cnt_d   = shamt;
            state_d = StRun;
          end else begin
            // HOLD, 111, or a shift/rotate by zero: acknowledge without touching q.
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        q_d       = step_q;
        ser_out_d = step_bit;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mode_q    <= MODE_HOLD;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign busy    = (state_q == StRun);
  assign done    = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed table-driven bench for the universal shift register (WIDTH=6), plus hand-written
// sequences for start-while-busy and asynchronous reset mid-run.
module tb_shift_register_universal;

  localparam int W  = 6;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_SAR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_H111 = 3'b111;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] shamt;
  logic [W-1:0]  load_data;
  logic          ser_in_l;
  logic          ser_in_r;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  shift_register_universal #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .shamt    (shamt),
    .load_data(load_data),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [CW-1:0] shamt;
    logic [W-1:0]  load;
    logic          sil;
    logic          sir;
    logic [W-1:0]  exp_q;
    logic          exp_ser;
    int            exp_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] m, input logic [CW-1:0] n, input logic [W-1:0] ld,
                       input logic sl, input logic sr);
    @(negedge clk);
    mode      = m;
    shamt     = n;
    load_data = ld;
    ser_in_l  = sl;
    ser_in_r  = sr;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts busy cycles until done is seen at a negedge; bounded.
  task automatic wait_done(output int busy_n, output bit ok);
    busy_n = 0;
    ok     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] exp_q, input logic exp_ser,
                           input int exp_busy);
    int  bn;
    bit  ok;
    wait_done(bn, ok);
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    check({tag, " busy_cycles"}, 32'(bn), 32'(exp_busy));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " q"}, 32'(q), 32'(exp_q));
    check({tag, " ser_out"}, 32'(ser_out), 32'(exp_ser));
    @(negedge clk);
    check({tag, " done_pulse_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{M_LOAD, 3'd0, 6'b101101, 1'b0, 1'b0, 6'b101101, 1'b0, 0};
    vecs[1]  = '{M_SHL,  3'd2, 6'b000000, 1'b0, 1'b0, 6'b110100, 1'b0, 2};
    vecs[2]  = '{M_LOAD, 3'd0, 6'b100100, 1'b0, 1'b0, 6'b100100, 1'b0, 0};
    vecs[3]  = '{M_SAR,  3'd3, 6'b000000, 1'b0, 1'b0, 6'b111100, 1'b1, 3};
    vecs[4]  = '{M_LOAD, 3'd0, 6'b000011, 1'b0, 1'b0, 6'b000011, 1'b1, 0};
    vecs[5]  = '{M_ROR,  3'd6, 6'b000000, 1'b0, 1'b0, 6'b000011, 1'b0, 6};
    vecs[6]  = '{M_ROL,  3'd1, 6'b000000, 1'b0, 1'b0, 6'b000110, 1'b0, 1};
    vecs[7]  = '{M_LOAD, 3'd0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 0};
    vecs[8]  = '{M_SHR,  3'd4, 6'b000000, 1'b0, 1'b1, 6'b111100, 1'b0, 4};
    vecs[9]  = '{M_SHL,  3'd7, 6'b000000, 1'b1, 1'b0, 6'b111111, 1'b1, 7};
    vecs[10] = '{M_HOLD, 3'd3, 6'b010101, 1'b0, 1'b0, 6'b111111, 1'b1, 0};
    vecs[11] = '{M_H111, 3'd3, 6'b010101, 1'b0, 1'b0, 6'b111111, 1'b1, 0};
    vecs[12] = '{M_ROL,  3'd0, 6'b010101, 1'b0, 1'b0, 6'b111111, 1'b1, 0};
    vecs[13] = '{M_LOAD, 3'd0, 6'b010110, 1'b0, 1'b0, 6'b010110, 1'b1, 0};
    vecs[14] = '{M_SHL,  3'd1, 6'b000000, 1'b0, 1'b0, 6'b101100, 1'b0, 1};
    vecs[15] = '{M_SAR,  3'd2, 6'b000000, 1'b0, 1'b0, 6'b111011, 1'b0, 2};

    reset_n   = 1'b0;
    start     = 1'b0;
    mode      = M_HOLD;
    shamt     = '0;
    load_data = '0;
    ser_in_l  = 1'b0;
    ser_in_r  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset q", 32'(q), 32'd0);
    check("reset ser_out", 32'(ser_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].mode, vecs[i].shamt, vecs[i].load, vecs[i].sil, vecs[i].sir);
      finish_op($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_ser, vecs[i].exp_busy);
    end

    // Start with LOAD while busy must be ignored: 111011 SHL 3 (fill 0) -> 011000, ser_out 1.
    issue(M_SHL, 3'd3, 6'b000000, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    mode      = M_LOAD;
    load_data = 6'b111111;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("ignore_load", 6'b011000, 1'b1, 2);

    // Shift by zero acts as HOLD: done right away, q unchanged.
    issue(M_SHL, 3'd0, 6'b000000, 1'b1, 1'b0);
    finish_op("shl_zero", 6'b011000, 1'b1, 0);

    // Asynchronous reset between edges in the middle of a run.
    issue(M_ROR, 3'd5, 6'b000000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst q", 32'(q), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst ser_out", 32'(ser_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(M_LOAD, 3'd0, 6'b000101, 1'b0, 1'b0);
    finish_op("post_rst_load", 6'b000101, 1'b0, 0);
    issue(M_SHR, 3'd1, 6'b000000, 1'b0, 1'b0);
    finish_op("post_rst_shr", 6'b000010, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
